// File: rtl/slave_port_loader_if.sv
// rtl/slave_port_loader_if.sv - command/response, run handshake and slave RAM port bundle
interface slave_port_loader_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 64,
   parameter int SIZE_W = 7
) ();
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [1:0]            cmd_op;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [SIZE_W-1:0]     cmd_size;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_data;
   logic                  rsp_error;
   logic                  start_port;
   logic                  done_port;
   logic [1:0]            S_oe_ram;
   logic [1:0]            S_we_ram;
   logic [2*ADDR_W-1:0]   S_addr_ram;
   logic [2*DATA_W-1:0]   S_Wdata_ram;
   logic [2*SIZE_W-1:0]   S_data_ram_size;
   logic [2*DATA_W-1:0]   Sout_Rdata_ram;
   logic [1:0]            Sout_DataRdy;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size, rsp_ready,
             done_port, Sout_Rdata_ram, Sout_DataRdy,
      output cmd_ready, rsp_valid, rsp_data, rsp_error, start_port,
             S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_size, rsp_ready,
             done_port, Sout_Rdata_ram, Sout_DataRdy,
      input  cmd_ready, rsp_valid, rsp_data, rsp_error, start_port,
             S_oe_ram, S_we_ram, S_addr_ram, S_Wdata_ram, S_data_ram_size
   );
endinterface

// File: rtl/slave_port_loader.sv
// rtl/slave_port_loader.sv - executes READ/WRITE/RUN commands against the accelerator slave port
module slave_port_loader #(
   parameter int ADDR_W      = 9,
   parameter int DATA_W      = 64,
   parameter int SIZE_W      = 7,
   parameter int ACC_TIMEOUT = 1024,
   parameter int RUN_TIMEOUT = 2**30
) (
   input logic                clock,
   input logic                reset,
   slave_port_loader_if.master bus
);
   localparam logic [1:0] OP_READ  = 2'd0;
   localparam logic [1:0] OP_WRITE = 2'd1;
   localparam logic [1:0] OP_RUN   = 2'd2;
   localparam int ACC_CW = $clog2(ACC_TIMEOUT) + 1;
   localparam logic [ACC_CW-1:0] ACC_LAST  = ACC_CW'(ACC_TIMEOUT - 1);
   localparam logic [DATA_W-1:0] RUN_LIMIT = DATA_W'(RUN_TIMEOUT);

   typedef enum logic [2:0] {IDLE, ACC, RUN_START, RUN_WAIT, RESP} state_t;

   state_t              state_q, state_d;
   logic                is_write_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [SIZE_W-1:0]   size_q;
   logic [ACC_CW-1:0]   acc_cnt_q;
   logic [DATA_W-1:0]   run_cnt_q;
   logic [DATA_W-1:0]   rsp_data_q;
   logic                rsp_error_q;
   logic                cmd_ready_c, start_c, oe0_c, we0_c;
   logic                size_ok, cmd_illegal, accept, rdy0, acc_last, run_limit;
   logic [DATA_W-1:0]   run_cnt_inc;
   logic                unused_inputs;

   assign size_ok     = (bus.cmd_size == SIZE_W'(8))  || (bus.cmd_size == SIZE_W'(16)) ||
                        (bus.cmd_size == SIZE_W'(32)) || (bus.cmd_size == SIZE_W'(64));
   assign cmd_illegal = (bus.cmd_op == 2'd3) || ((bus.cmd_op != OP_RUN) && !size_ok);
   assign accept      = cmd_ready_c && bus.cmd_valid;
   assign rdy0        = bus.Sout_DataRdy[0];
   assign acc_last    = (acc_cnt_q == ACC_LAST);
   assign run_limit   = (run_cnt_q >= RUN_LIMIT);
   assign run_cnt_inc = (&run_cnt_q) ? run_cnt_q : run_cnt_q + DATA_W'(1);
   assign unused_inputs = ^{bus.Sout_Rdata_ram[2*DATA_W-1:DATA_W], bus.Sout_DataRdy[1]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      cmd_ready_c = 1'b0;
      start_c     = 1'b0;
      oe0_c       = 1'b0;
      we0_c       = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready_c = !reset;
            if (accept) begin
               if (cmd_illegal)                 state_d = RESP;
               else if (bus.cmd_op == OP_RUN)   state_d = RUN_START;
               else                             state_d = ACC;
            end
         end
         ACC: begin
            oe0_c = !is_write_q;
            we0_c = is_write_q;
            if (rdy0 || acc_last) state_d = RESP;
         end
         RUN_START: begin
            start_c = 1'b1;
            state_d = RUN_WAIT;
         end
         RUN_WAIT: begin
            if (bus.done_port || run_limit) state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // run_cnt_q always holds the 1-based index of the current cycle since the start pulse
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         is_write_q  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         size_q      <= '0;
         acc_cnt_q   <= '0;
         run_cnt_q   <= '0;
         rsp_data_q  <= '0;
         rsp_error_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               is_write_q  <= (bus.cmd_op == OP_WRITE);
               addr_q      <= bus.cmd_addr;
               wdata_q     <= bus.cmd_wdata;
               size_q      <= bus.cmd_size;
               acc_cnt_q   <= '0;
               run_cnt_q   <= DATA_W'(1);
               rsp_data_q  <= '0;
               rsp_error_q <= cmd_illegal;
            end
            ACC: begin
               if (rdy0) begin
                  rsp_data_q  <= is_write_q ? '0 : bus.Sout_Rdata_ram[DATA_W-1:0];
                  rsp_error_q <= 1'b0;
               end else if (acc_last) begin
                  rsp_data_q  <= '0;
                  rsp_error_q <= 1'b1;
               end else begin
                  acc_cnt_q <= acc_cnt_q + ACC_CW'(1);
               end
            end
            RUN_START: run_cnt_q <= run_cnt_inc;
            RUN_WAIT: begin
               if (bus.done_port) begin
                  rsp_data_q  <= run_cnt_q;
                  rsp_error_q <= 1'b0;
               end else if (run_limit) begin
                  rsp_data_q  <= run_cnt_q;
                  rsp_error_q <= 1'b1;
               end else begin
                  run_cnt_q <= run_cnt_inc;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cmd_ready       = cmd_ready_c;
   assign bus.rsp_valid       = (state_q == RESP);
   assign bus.rsp_data        = rsp_data_q;
   assign bus.rsp_error       = rsp_error_q;
   assign bus.start_port      = start_c;
   assign bus.S_oe_ram        = {1'b0, oe0_c};
   assign bus.S_we_ram        = {1'b0, we0_c};
   assign bus.S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
   assign bus.S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
   assign bus.S_data_ram_size = {{SIZE_W{1'b0}}, size_q};
endmodule

// File: tb/tb_slave_port_loader.sv
// tb/tb_slave_port_loader.sv - directed table, random model-checked and reset sequences for slave_port_loader
module tb_slave_port_loader;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 64;
   localparam int SIZE_W = 7;
   localparam int ACC_TO = 16;
   localparam int RUN_TO = 40;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   slave_port_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W)) bus ();

   slave_port_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
                       .ACC_TIMEOUT(ACC_TO), .RUN_TIMEOUT(RUN_TO)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   typedef struct {
      logic [1:0]  op;
      logic [8:0]  addr;
      logic [63:0] wdata;
      logic [6:0]  size;
      int          lat;       // DataRdy in strobe cycle lat+1; -1 = never
      int          done_lat;  // done_port this many cycles after start; 0 = never
      bit          early;     // also raise done_port during the start cycle
      logic [63:0] exp_data;
      bit          exp_err;
      int          exp_strobe;
      int          exp_start;
   } vec_t;

   int checks = 0;
   int errors = 0;
   logic [63:0] acc_mem [int];
   logic [63:0] ref_mem [int];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_addr = 0; bus.cmd_wdata = 0; bus.cmd_size = 0;
      bus.rsp_ready = 0; bus.done_port = 0; bus.Sout_Rdata_ram = 0; bus.Sout_DataRdy = 0;
   endtask

   task automatic issue(input vec_t v);
      bus.cmd_valid = 1; bus.cmd_op = v.op; bus.cmd_addr = v.addr;
      bus.cmd_wdata = v.wdata; bus.cmd_size = v.size;
      check("accept_ready", bus.cmd_ready, 1);
      @(posedge clock); #1;
      bus.cmd_valid = 0;
      bus.cmd_wdata = {$urandom, $urandom};
   endtask

   // Reference model: outcome of a command derived from the command rules alone
   task automatic model(inout vec_t v);
      bit legal = (v.size == 8) || (v.size == 16) || (v.size == 32) || (v.size == 64);
      v.exp_data = 0; v.exp_err = 0; v.exp_strobe = 0; v.exp_start = 0;
      if (v.op == 3 || (v.op != 2 && !legal)) begin
         v.exp_err = 1;
      end else if (v.op == 2) begin
         v.exp_start = 1;
         if (v.done_lat >= 1 && v.done_lat + 1 <= RUN_TO) v.exp_data = v.done_lat + 1;
         else begin v.exp_data = RUN_TO; v.exp_err = 1; end
      end else if (v.lat >= 0 && v.lat + 1 <= ACC_TO) begin
         v.exp_strobe = v.lat + 1;
         if (v.op == 0) v.exp_data = ref_mem.exists(int'(v.addr)) ? ref_mem[int'(v.addr)] : 64'h0;
         else ref_mem[int'(v.addr)] = v.wdata;
      end else begin
         v.exp_strobe = ACC_TO;
         v.exp_err = 1;
      end
   endtask

   task automatic apply(input vec_t v, input int hold);
      logic [63:0] data;
      bit err, got, both, ch1, busbad;
      int strobe, starts, s_cyc;
      logic [63:0] rd;
      issue(v);
      strobe = 0; starts = 0; s_cyc = -1; got = 0; both = 0; ch1 = 0; busbad = 0;
      data = 0; err = 0;
      for (int cyc = 1; cyc <= 200 && !got; cyc++) begin
         bus.Sout_DataRdy = {1'($urandom), 1'b0};
         bus.Sout_Rdata_ram = {$urandom, $urandom, $urandom, $urandom};
         bus.done_port = (v.op != 2) ? 1'($urandom) : 1'b0;
         if (bus.rsp_valid) begin
            got = 1; data = bus.rsp_data; err = bus.rsp_error;
         end else begin
            if (bus.S_oe_ram[0] && bus.S_we_ram[0]) both = 1;
            if (bus.S_oe_ram[1] || bus.S_we_ram[1] || |bus.S_addr_ram[2*ADDR_W-1:ADDR_W] ||
                |bus.S_Wdata_ram[2*DATA_W-1:DATA_W] || |bus.S_data_ram_size[2*SIZE_W-1:SIZE_W]) ch1 = 1;
            if (bus.S_oe_ram[0] || bus.S_we_ram[0]) begin
               strobe++;
               if (bus.S_addr_ram[ADDR_W-1:0] !== v.addr || bus.S_data_ram_size[SIZE_W-1:0] !== v.size) busbad = 1;
               if (bus.S_we_ram[0] && bus.S_Wdata_ram[DATA_W-1:0] !== v.wdata) busbad = 1;
               bus.Sout_DataRdy[0] = 1'b0;
               if (v.lat >= 0 && strobe == v.lat + 1) begin
                  bus.Sout_DataRdy[0] = 1'b1;
                  rd = acc_mem.exists(int'(bus.S_addr_ram[ADDR_W-1:0])) ? acc_mem[int'(bus.S_addr_ram[ADDR_W-1:0])] : 64'h0;
                  if (bus.S_oe_ram[0]) bus.Sout_Rdata_ram[DATA_W-1:0] = rd;
                  if (bus.S_we_ram[0]) acc_mem[int'(bus.S_addr_ram[ADDR_W-1:0])] = bus.S_Wdata_ram[DATA_W-1:0];
               end
            end
            if (bus.start_port) begin starts++; s_cyc = cyc; end
            if (s_cyc >= 0 && ((v.done_lat > 0 && cyc == s_cyc + v.done_lat) || (v.early && cyc == s_cyc)))
               bus.done_port = 1;
            @(posedge clock); #1;
         end
      end
      bus.Sout_DataRdy = 0; bus.done_port = 0;
      check("rsp_seen", got, 1);
      check("rsp_data", data, v.exp_data);
      check("rsp_error", err, v.exp_err);
      check("strobe_cycles", strobe, v.exp_strobe);
      check("start_pulses", starts, v.exp_start);
      check("oe_we_exclusive", both, 0);
      check("channel1_zero", ch1, 0);
      check("bus_fields_held", busbad, 0);
      if (got) begin
         repeat (hold) @(posedge clock);
         #1;
         if (hold > 0) begin
            check("rsp_hold_valid", bus.rsp_valid, 1);
            check("rsp_hold_data", bus.rsp_data, data);
         end
         bus.rsp_ready = 1;
         @(posedge clock); #1;
         bus.rsp_ready = 0;
         check("rsp_drop", bus.rsp_valid, 0);
         check("ready_after_rsp", bus.cmd_ready, 1);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [8:0] addr, input logic [63:0] wdata,
                               input logic [6:0] size, input int lat, input int done_lat, input bit early,
                               input logic [63:0] exp_data, input bit exp_err, input int exp_strobe,
                               input int exp_start);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.size = size; v.lat = lat;
      v.done_lat = done_lat; v.early = early; v.exp_data = exp_data; v.exp_err = exp_err;
      v.exp_strobe = exp_strobe; v.exp_start = exp_start;
      return v;
   endfunction

   task automatic outputs_zero(input string name);
      check(name, {bus.cmd_ready, bus.rsp_valid, bus.start_port, bus.S_oe_ram, bus.S_we_ram}, 0);
   endtask

   vec_t dir_tab [10];
   vec_t v;
   int   r;
   logic [6:0] legal_sizes [4];
   logic [6:0] bad_sizes [4];

   initial begin
      idle_inputs();
      reset = 1;
      #1;
      outputs_zero("reset_outputs");
      check("reset_rsp_data", bus.rsp_data, 0);
      @(posedge clock); #1;
      reset = 0;
      #1;
      check("ready_after_reset", bus.cmd_ready, 1);

      dir_tab[0] = mk(2'd1, 9'h010, 64'hDEAD, 7'd32,  1,  0, 0, 64'h0,    0,  2, 0);
      dir_tab[1] = mk(2'd0, 9'h010, 64'h0,    7'd32,  3,  0, 0, 64'hDEAD, 0,  4, 0);
      dir_tab[2] = mk(2'd2, 9'h000, 64'h0,    7'd32,  0,  5, 0, 64'd6,    0,  0, 1);
      dir_tab[3] = mk(2'd0, 9'h020, 64'h0,    7'd64, -1,  0, 0, 64'h0,    1, 16, 0);
      dir_tab[4] = mk(2'd0, 9'h010, 64'h0,    7'd12,  1,  0, 0, 64'h0,    1,  0, 0);
      dir_tab[5] = mk(2'd3, 9'h010, 64'h0,    7'd32,  1,  0, 0, 64'h0,    1,  0, 0);
      dir_tab[6] = mk(2'd2, 9'h000, 64'h0,    7'd8,   0,  0, 1, 64'd40,   1,  0, 1);
      dir_tab[7] = mk(2'd2, 9'h000, 64'h0,    7'd8,   0, 39, 0, 64'd40,   0,  0, 1);
      dir_tab[8] = mk(2'd1, 9'h1FF, 64'h1234_5678_9ABC_DEF0, 7'd8, 15, 0, 0, 64'h0, 0, 16, 0);
      dir_tab[9] = mk(2'd2, 9'h000, 64'h0,    7'd16,  0,  1, 1, 64'd2,    0,  0, 1);
      for (int i = 0; i < 10; i++) apply(dir_tab[i], i % 3);

      // reset while waiting in the memory access, then a normal command
      acc_mem.delete(); ref_mem.delete();
      issue(mk(2'd0, 9'h005, 64'h0, 7'd32, -1, 0, 0, 64'h0, 0, 0, 0));
      repeat (3) @(posedge clock);
      #1;
      check("oe_before_reset", bus.S_oe_ram[0], 1);
      #2 reset = 1;
      #1 outputs_zero("reset_mid_acc");
      @(posedge clock); #1 reset = 0;
      #1;
      apply(mk(2'd1, 9'h005, 64'hCAFE, 7'd16, 2, 0, 0, 64'h0, 0, 3, 0), 0);
      apply(mk(2'd0, 9'h005, 64'h0,    7'd16, 0, 0, 0, 64'hCAFE, 0, 1, 0), 1);

      // reset while waiting for done_port, then a normal run
      issue(mk(2'd2, 9'h000, 64'h0, 7'd32, 0, 0, 0, 64'h0, 0, 0, 1));
      repeat (4) @(posedge clock);
      #1;
      check("run_wait_no_rsp", bus.rsp_valid, 0);
      #2 reset = 1;
      #1 outputs_zero("reset_mid_run");
      @(posedge clock); #1 reset = 0;
      #1;
      apply(mk(2'd2, 9'h000, 64'h0, 7'd32, 0, 3, 0, 64'd4, 0, 0, 1), 0);

      // randomized commands against the reference model
      acc_mem.delete(); ref_mem.delete();
      legal_sizes[0] = 7'd8;  legal_sizes[1] = 7'd16; legal_sizes[2] = 7'd32;  legal_sizes[3] = 7'd64;
      bad_sizes[0]   = 7'd0;  bad_sizes[1]   = 7'd12; bad_sizes[2]   = 7'd33;  bad_sizes[3]   = 7'd127;
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         v.op = (r <= 3) ? 2'd0 : (r <= 6) ? 2'd1 : (r <= 8) ? 2'd2 : 2'd3;
         v.addr = 9'($urandom_range(0, 7));
         v.wdata = {$urandom, $urandom};
         v.size = legal_sizes[$urandom_range(0, 3)];
         if (v.op != 2 && $urandom_range(0, 5) == 0) v.size = bad_sizes[$urandom_range(0, 3)];
         r = $urandom_range(0, 19);
         v.lat = (r >= 17) ? -1 : r;
         v.done_lat = $urandom_range(0, 44);
         v.early = 1'($urandom_range(0, 1));
         model(v);
         apply(v, $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
